md4_digest_matcher: RTL
=======================

Name: md4_digest_matcher

Overview:
- Downstream consumer of the md4 hasher's serial digest port.
- Collects the 16 digest bytes of each hashed candidate, compares them on the fly against a loaded target digest, and reports match/no-match per candidate.
- Keeps the index of the first matching candidate and a checked-hash counter, and raises a sticky halt to the candidate generator.

Parameters:
- DIGEST_BYTES, 16, bytes per digest; fixed for MD4, parameterised only for reuse.
- IDX_W, 32, width of the candidate index.
- CNT_W, 32, width of the hashes_checked counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- target_byte  in  8  target digest byte, byte 0 (A[7:0]) first.
- target_write  in  1  qualifies target_byte; accepted only in LOAD.
- target_clear  in  1  one-cycle pulse; returns the block to LOAD and clears all results.
- in_byte  in  8  digest byte from the hasher, byte 0 first.
- in_write  in  1  qualifies in_byte.
- in_ready  out  1  high when a digest byte can be accepted; drives the hasher's output_full input.
- cand_index  in  IDX_W  index of the candidate being hashed; sampled with digest byte 0.
- armed  out  1  target fully loaded.
- digest_done  out  1  one-cycle pulse per completed digest.
- match  out  1  one-cycle pulse, coincident with digest_done, when the digest equals the target.
- found  out  1  sticky; set by the first match.
- halt  out  1  equals found; tells the generator to stop.
- match_index  out  IDX_W  cand_index of the first match; holds until clear.
- hashes_checked  out  CNT_W  completed digests, saturating.
- last_digest  out  128  most recent complete digest, byte 0 in bits [7:0].

Behaviour:
- Reset values: all outputs 0; state LOAD; target, byte counters and mismatch flag 0.
- States and transitions:
  - LOAD: in_ready=0; each target_write stores a byte at tgt_cnt and increments tgt_cnt. On the 16th byte: armed=1, next state COLLECT. in_write is ignored.
  - COLLECT: in_ready=1. A byte is accepted when in_write is high; it is stored at byte_cnt, and mismatch |= (in_byte != target[byte_cnt]). cand_index is captured when byte_cnt==0. On the 16th accepted byte, next state RESULT. target_write is ignored.
  - RESULT: exactly one cycle; in_ready=0.
    - digest_done=1.
    - match = ~mismatch_final, where mismatch_final includes byte 15.
    - Updates last_digest.
    - hashes_checked increments unless all ones.
    - On match with found==0: found=1 and match_index=captured index.
    - byte_cnt=0, mismatch=0, next state COLLECT.
- Latency: digest_done/match is asserted in the cycle after the cycle that accepts byte 15.
- Throughput: one digest per 17 cycles minimum.
- Gaps: in_write may drop between bytes; partial digests persist indefinitely.
- A later match after found=1 pulses match, but match_index and found are unchanged.
- target_clear has highest priority in any state:
  - next state LOAD; tgt_cnt, byte_cnt, mismatch, armed, found, halt, match_index and hashes_checked cleared.
  - An in_write in the same cycle is dropped.
  - last_digest is retained.
- target_write outside LOAD: ignored, no error.
- reset mid-digest: asynchronous return to LOAD and reset values; a partial digest is discarded.
- All compares are byte-wise equality; no arithmetic beyond counters.
  - byte_cnt and tgt_cnt are 5 bits wide and never exceed 16.

Decomposition:
- md4_pkg holds:
  - DIGEST_BYTES;
  - MD4_EMPTY_DIGEST constant (31d6cfe0d16ae931b73c59d7e0c089c0);
  - the state encoding LOAD/COLLECT/RESULT.
- One sub-module, digest_capture: 16-byte indexed register file with a write enable and byte index, instantiated twice (target, last digest).
- The compare logic and FSM stay in md4_digest_matcher.

Test Plan:
1. Load MD4_EMPTY_DIGEST, cand_index=0x2A, stream the same 16 bytes back-to-back -> digest_done and match high in cycle 17; found=halt=1; match_index=0x2A; hashes_checked=1.
2. Same target, stream a digest differing only in byte 15 (0xc1) -> digest_done=1, match=0, found=0, last_digest shows 0xc1 in bits [127:120].
3. Match at index 5, then a second match at index 9 -> second match pulse occurs; match_index stays 5; hashes_checked=2.
4. Hold in_write low for 3 cycles between bytes 7 and 8, plus an in_write while in LOAD -> LOAD byte ignored; result identical to scenario 1, with latency counted from byte 15; in_ready=0 during LOAD and RESULT.
5. target_clear after byte 10 of a digest, coincident with an in_write -> state LOAD, armed=0, counters 0, byte dropped; reload target and a full digest matches correctly.
6. CNT_W=4: complete 20 non-matching digests -> hashes_checked saturates at 15; async reset asserted mid-digest -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/md4_pkg.sv
// Shared definitions for the MD4 digest matcher: digest size, the well-known empty-string digest
// and the matcher state encoding.
package md4_pkg;
    localparam int DIGEST_BYTES = 16;

    // MD4("") = 31d6cfe0d16ae931b73c59d7e0c089c0, packed with byte 0 in bits [7:0]
    localparam logic [127:0] MD4_EMPTY_DIGEST = 128'hc089c0e0_d7593cb7_31e96ad1_e0cfd631;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;
endpackage

// File: rtl/digest_capture.sv
// Byte-indexed digest register file; the committed image is published only when the final byte
// of a digest is written, so readers never see a partially written digest.
module digest_capture #(
    parameter int NBYTES = md4_pkg::DIGEST_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [4:0]          wr_idx,
    input  logic [7:0]          wr_byte,
    input  logic                commit,
    output logic [8*NBYTES-1:0] data
);
    import md4_pkg::*;

    logic [8*NBYTES-1:0] bytes_q;
    logic [8*NBYTES-1:0] bytes_d;

    always_comb begin
        bytes_d = bytes_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_en && wr_idx == 5'(i)) begin
                bytes_d[8*i +: 8] = wr_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bytes_q <= '0;
            data    <= '0;
        end else begin
            bytes_q <= bytes_d;
            if (commit) begin
                data <= bytes_d;
            end
        end
    end
endmodule

// File: rtl/md4_digest_matcher.sv
// Collects serial MD4 digests, compares them on the fly against a loaded target and records the
// first matching candidate index plus a saturating count of checked hashes.
module md4_digest_matcher #(
    parameter int DIGEST_BYTES = md4_pkg::DIGEST_BYTES,
    parameter int IDX_W        = 32,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                target_byte,
    input  logic                      target_write,
    input  logic                      target_clear,
    input  logic [7:0]                in_byte,
    input  logic                      in_write,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          cand_index,
    output logic                      armed,
    output logic                      digest_done,
    output logic                      match,
    output logic                      found,
    output logic                      halt,
    output logic [IDX_W-1:0]          match_index,
    output logic [CNT_W-1:0]          hashes_checked,
    output logic [8*DIGEST_BYTES-1:0] last_digest
);
    import md4_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(DIGEST_BYTES - 1);

    state_t                    state;
    logic [4:0]                tgt_cnt;
    logic [4:0]                byte_cnt;
    logic                      mismatch;
    logic [IDX_W-1:0]          cap_index;
    logic [8*DIGEST_BYTES-1:0] target;
    logic [7:0]                tgt_byte;
    logic                      tgt_wr;
    logic                      accept;
    logic                      last_byte;
    logic                      digest_ok;

    assign tgt_wr    = (state == LOAD) && target_write && !target_clear;
    assign accept    = (state == COLLECT) && in_write && !target_clear;
    assign last_byte = (byte_cnt == LAST_IDX);
    assign digest_ok = !(mismatch || (in_byte != tgt_byte));
    assign halt      = found;

    always_comb begin
        tgt_byte = '0;
        for (int i = 0; i < DIGEST_BYTES; i++) begin
            if (byte_cnt == 5'(i)) begin
                tgt_byte = target[8*i +: 8];
            end
        end
    end

    digest_capture #(.NBYTES(DIGEST_BYTES)) u_target (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tgt_wr),
        .wr_idx  (tgt_cnt),
        .wr_byte (target_byte),
        .commit  (tgt_wr && tgt_cnt == LAST_IDX),
        .data    (target)
    );

    digest_capture #(.NBYTES(DIGEST_BYTES)) u_last (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_idx  (byte_cnt),
        .wr_byte (in_byte),
        .commit  (accept && last_byte),
        .data    (last_digest)
    );

    // Results are registered on the edge that accepts the final byte, so they are all visible
    // during the single RESULT cycle together with digest_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= LOAD;
            tgt_cnt        <= '0;
            byte_cnt       <= '0;
            mismatch       <= 1'b0;
            cap_index      <= '0;
            in_ready       <= 1'b0;
            armed          <= 1'b0;
            digest_done    <= 1'b0;
            match          <= 1'b0;
            found          <= 1'b0;
            match_index    <= '0;
            hashes_checked <= '0;
        end else begin
            digest_done <= 1'b0;
            match       <= 1'b0;
            if (target_clear) begin
                state          <= LOAD;
                tgt_cnt        <= '0;
                byte_cnt       <= '0;
                mismatch       <= 1'b0;
                in_ready       <= 1'b0;
                armed          <= 1'b0;
                found          <= 1'b0;
                match_index    <= '0;
                hashes_checked <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (target_write) begin
                            tgt_cnt <= tgt_cnt + 5'd1;
                            if (tgt_cnt == LAST_IDX) begin
                                armed    <= 1'b1;
                                in_ready <= 1'b1;
                                state    <= COLLECT;
                            end
                        end
                    end
                    COLLECT: begin
                        if (in_write) begin
                            if (byte_cnt == 5'd0) begin
                                cap_index <= cand_index;
                            end
                            if (last_byte) begin
                                state       <= RESULT;
                                in_ready    <= 1'b0;
                                digest_done <= 1'b1;
                                match       <= digest_ok;
                                byte_cnt    <= '0;
                                mismatch    <= 1'b0;
                                if (hashes_checked != '1) begin
                                    hashes_checked <= hashes_checked + 1'b1;
                                end
                                if (digest_ok && !found) begin
                                    found       <= 1'b1;
                                    match_index <= (byte_cnt == 5'd0) ? cand_index : cap_index;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 5'd1;
                                mismatch <= !digest_ok;
                            end
                        end
                    end
                    RESULT: begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                    default: begin
                        state    <= LOAD;
                        in_ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
